// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: hash-size encodings, round counts, sequencer states.
package sha2_pkg;

   typedef enum logic [1:0] {
      HS_ILLEGAL = 2'b00,
      HS_SHA256  = 2'b01,
      HS_SHA384  = 2'b10,
      HS_SHA512  = 2'b11
   } hash_size_e;

   localparam int SHA256_ROUNDS = 64;
   localparam int SHA512_ROUNDS = 80;
   localparam int FFWD_LEN      = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FFWD,
      ST_DONE
   } state_e;

   // Highest count RUN may reach (R-5); the next count (R-4) starts the feed-forward.
   function automatic logic [6:0] run_max_cnt(input hash_size_e hs);
      return (hs == HS_SHA256) ? 7'(SHA256_ROUNDS - FFWD_LEN - 1)
                               : 7'(SHA512_ROUNDS - FFWD_LEN - 1);
   endfunction

endpackage

// File: rtl/sha_ffwd_add.sv
// Feed-forward adder: 64-bit modular add, or 32-bit add zero-extended for SHA-256.
module sha_ffwd_add (
   input  logic [63:0] x_i,
   input  logic [63:0] y_i,
   input  logic        mode32_i,
   output logic [63:0] sum_o
);

   logic [31:0] sum32;
   logic [63:0] sum64;

   // Both widths wrap naturally; the SHA-256 carry out of bit 31 is dropped.
   assign sum32 = x_i[31:0] + y_i[31:0];
   assign sum64 = x_i + y_i;
   assign sum_o = mode32_i ? {32'h0, sum32} : sum64;

endmodule

// File: rtl/sha_hout_ffwd.sv
// SHA-2 round sequencer and digest feed-forward writer into the hash-state bank.
module sha_hout_ffwd
   import sha2_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         blk_start,
   input  logic         last_blk,
   input  logic [1:0]   hash_size,
   input  logic         rnd_en,
   input  logic         work_valid,
   input  logic [511:0] work_state,
   input  logic [63:0]  hin_init_a,
   input  logic [63:0]  hin_init_e,
   output logic         hin_start,
   output logic [6:0]   cnt,
   output logic [63:0]  hin_init_a_new,
   output logic [63:0]  hin_init_e_new,
   output logic         busy,
   output logic         digest_valid,
   output logic         err
);

   state_e      state_q;
   logic [6:0]  cnt_q;
   hash_size_e  size_q;
   logic        last_q;
   logic        hin_start_q;
   logic        err_q;
   logic        digest_valid_q;
   // Words 0..3 = a..d (A lane), 4..7 = e..h (E lane); index 3/7 feeds the adders.
   logic [63:0] work_q [8];

   logic [6:0]  run_max;
   logic [6:0]  ffwd_last;
   logic        start_ok;
   logic        in_ffwd;
   logic [63:0] sum_a;
   logic [63:0] sum_e;

   assign run_max   = run_max_cnt(size_q);
   assign ffwd_last = run_max + 7'(FFWD_LEN);
   assign start_ok  = start && (hash_size != HS_ILLEGAL);
   assign in_ffwd   = (state_q == ST_FFWD);

   // Sequencer FSM with round counter, operand shift register and registered pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         size_q         <= HS_SHA256;
         last_q         <= 1'b0;
         hin_start_q    <= 1'b0;
         err_q          <= 1'b0;
         digest_valid_q <= 1'b0;
         // NOTE: the small operand array is reset explicitly so a reset mid-FFWD
         // leaves no stale working variables behind.
         work_q         <= '{default: '0};
      end else begin
         // NOTE: every register here uses <= so all of them see pre-edge values.
         hin_start_q    <= 1'b0;
         err_q          <= 1'b0;
         digest_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (start) begin
                  if (start_ok) begin
                     hin_start_q <= 1'b1;
                     size_q      <= hash_size_e'(hash_size);
                     last_q      <= last_blk;
                     state_q     <= ST_RUN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (blk_start) begin
                  last_q  <= last_blk;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (start_ok) begin
                  // Abort the block and restart from the IV.
                  hin_start_q <= 1'b1;
                  size_q      <= hash_size_e'(hash_size);
                  last_q      <= last_blk;
                  cnt_q       <= '0;
               end else begin
                  err_q <= start;
                  if (work_valid && (cnt_q == run_max)) begin
                     for (int i = 0; i < 8; i++) begin
                        work_q[i] <= work_state[511 - 64*i -: 64];
                     end
                     cnt_q   <= cnt_q + 7'd1;
                     state_q <= ST_FFWD;
                  end else if (rnd_en && (cnt_q != run_max)) begin
                     cnt_q <= cnt_q + 7'd1;
                  end
               end
            end
            ST_FFWD: begin
               // Present d/h, then c/g, b/f, a/e at the lane heads.
               for (int i = 3; i > 0; i--) begin
                  work_q[i]   <= work_q[i-1];
                  work_q[i+4] <= work_q[i+3];
               end
               work_q[0] <= '0;
               work_q[4] <= '0;
               if (cnt_q == ffwd_last) begin
                  cnt_q          <= '0;
                  digest_valid_q <= last_q;
                  state_q        <= last_q ? ST_DONE : ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 7'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   sha_ffwd_add u_add_a (
      .x_i      (hin_init_a),
      .y_i      (work_q[3]),
      .mode32_i (size_q == HS_SHA256),
      .sum_o    (sum_a)
   );

   sha_ffwd_add u_add_e (
      .x_i      (hin_init_e),
      .y_i      (work_q[7]),
      .mode32_i (size_q == HS_SHA256),
      .sum_o    (sum_e)
   );

   assign hin_init_a_new = in_ffwd ? sum_a : '0;
   assign hin_init_e_new = in_ffwd ? sum_e : '0;
   assign hin_start      = hin_start_q;
   assign cnt            = cnt_q;
   assign busy           = (state_q != ST_IDLE);
   assign digest_valid   = digest_valid_q;
   assign err            = err_q;

endmodule
